// File: rtl/viterbi_survivor_exchange_if.sv
// Handshake and data bundle between the ACS array / frame controller and the
// register-exchange survivor memory. The master drives trellis steps and
// flush requests. The slave returns decoded symbols and the end-of-frame pulse.
interface viterbi_survivor_exchange_if #(
    parameter int NSTATE = 4,
    parameter int SYMW   = 3
);
    localparam int BW = (NSTATE > 1) ? $clog2(NSTATE) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [NSTATE-1:0]      dec;
    logic [NSTATE*SYMW-1:0] sym;
    logic [BW-1:0]          best_state;
    logic                   flush;
    logic                   out_valid;
    logic [SYMW-1:0]        out_sym;
    logic                   frame_done;

    modport master (
        output in_valid, dec, sym, best_state, flush,
        input  in_ready, out_valid, out_sym, frame_done
    );

    modport slave (
        input  in_valid, dec, sym, best_state, flush,
        output in_ready, out_valid, out_sym, frame_done
    );
endinterface

// File: rtl/viterbi_survivor_exchange.sv
// Register-exchange survivor memory for the Viterbi decoder.
// On every accepted trellis step, each state's survivor is rebuilt from the
// predecessor chosen by its ACS decision. The predecessor's branch symbol is
// shifted into slot 0. Once the history is full, each step emits the oldest
// symbol of the best state. A flush drains the remaining history oldest-first.
module viterbi_survivor_exchange #(
    parameter int NSTATE = 4,
    parameter int SYMW   = 3,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    viterbi_survivor_exchange_if.slave    bus
);
    localparam int BW = (NSTATE > 1) ? $clog2(NSTATE) : 1;
    localparam int H  = NSTATE / 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Predecessor of state s selected by decision bit d (even s: a=j, b=j+H;
    // odd s: a=j+H, b=j).
    function automatic int pred_of(input int s, input logic d);
        int j;
        int a;
        int b;
        j = s >> 1;
        if ((s % 2) == 0) begin
            a = j;
            b = j + H;
        end else begin
            a = j + H;
            b = j;
        end
        return d ? b : a;
    endfunction

    logic [DEPTH*SYMW-1:0] surv_q [NSTATE];
    logic [DEPTH*SYMW-1:0] surv_d [NSTATE];
    state_t                state_q, state_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bl_q, bl_d;
    logic                  out_valid_q, out_valid_d;
    logic [SYMW-1:0]       out_sym_q, out_sym_d;
    logic                  frame_done_q, frame_done_d;

    logic                  in_ready_s;
    logic                  step_s;
    logic [CW-1:0]         fill_post_s;
    logic [SYMW-1:0]       drain_sym_s;
    logic [SYMW-1:0]       run_sym_s;

    assign in_ready_s = (state_q != ST_DRAIN);
    assign step_s     = bus.in_valid && in_ready_s;
    assign run_sym_s  = surv_q[bus.best_state][DEPTH*SYMW-1 -: SYMW];

    // Fill level after the current step, saturating at DEPTH.
    always_comb begin
        if (step_s && (fill_q != DEPTH_C)) begin
            fill_post_s = fill_q + ONE_C;
        end else begin
            fill_post_s = fill_q;
        end
    end

    // Select slot cnt-1 of the latched drain state's survivor.
    always_comb begin
        drain_sym_s = {SYMW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k + 1) == cnt_q) begin
                drain_sym_s = surv_q[bl_q][k*SYMW +: SYMW];
            end else begin
                drain_sym_s = drain_sym_s;
            end
        end
    end

    // Register exchange: all states rebuilt in parallel from pre-update values.
    always_comb begin
        for (int s = 0; s < NSTATE; s++) begin
            if (step_s) begin
                surv_d[s] = {surv_q[pred_of(s, bus.dec[s])][(DEPTH-1)*SYMW-1:0],
                             bus.sym[pred_of(s, bus.dec[s])*SYMW +: SYMW]};
            end else begin
                surv_d[s] = surv_q[s];
            end
        end
    end

    // Next-state and output logic for the fill/run/drain controller.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        bl_d         = bl_q;
        out_valid_d  = 1'b0;
        out_sym_d    = out_sym_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_FILL, ST_RUN: begin
                fill_d = fill_post_s;
                if (step_s && (state_q == ST_RUN)) begin
                    out_valid_d = 1'b1;
                    out_sym_d   = run_sym_s;
                end else begin
                    out_valid_d = 1'b0;
                end
                if (bus.flush) begin
                    bl_d = bus.best_state;
                    if (fill_post_s != ZERO_C) begin
                        cnt_d   = fill_post_s;
                        state_d = ST_DRAIN;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else if (fill_post_s == ZERO_C) begin
                    state_d = ST_IDLE;
                end else if (fill_post_s == DEPTH_C) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                out_sym_d   = drain_sym_s;
                cnt_d       = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    frame_done_d = 1'b1;
                    fill_d       = ZERO_C;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fill_d  = ZERO_C;
                cnt_d   = ZERO_C;
            end
        endcase
    end

    // State, survivor and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSTATE; s++) begin
                surv_q[s] <= {(DEPTH*SYMW){1'b0}};
            end
            state_q      <= ST_IDLE;
            fill_q       <= ZERO_C;
            cnt_q        <= ZERO_C;
            bl_q         <= {BW{1'b0}};
            out_valid_q  <= 1'b0;
            out_sym_q    <= {SYMW{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            for (int s = 0; s < NSTATE; s++) begin
                surv_q[s] <= surv_d[s];
            end
            state_q      <= state_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            bl_q         <= bl_d;
            out_valid_q  <= out_valid_d;
            out_sym_q    <= out_sym_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sym    = out_sym_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_viterbi_survivor_exchange.sv
// Directed bench for the register-exchange survivor memory, NSTATE=4, SYMW=3,
// DEPTH=4. It uses a table of predecessor-map vectors plus hand-written
// fill/run/drain/reset sequences.
module tb_viterbi_survivor_exchange;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    viterbi_survivor_exchange_if #(.NSTATE(4), .SYMW(3)) bus ();

    viterbi_survivor_exchange #(.NSTATE(4), .SYMW(3), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dec;
        logic [1:0] best;
        logic [2:0] exp_sym;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic drive(input logic v, input logic [3:0] d, input logic [11:0] s,
                         input logic [1:0] b, input logic f);
        bus.in_valid   = v;
        bus.dec        = d;
        bus.sym        = s;
        bus.best_state = b;
        bus.flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
        reset = 1'b0;
    endtask

    // Step carrying symbol v on predecessor 0 only, dec=0, best_state=0.
    task automatic step0(input logic [2:0] v, input logic f);
        drive(1'b1, 4'd0, {9'd0, v}, 2'd0, f);
    endtask

    initial begin
        logic [2:0] k3;
        vecs[0] = '{dec: 4'b0000, best: 2'd1, exp_sym: 3'd6};
        vecs[1] = '{dec: 4'b0010, best: 2'd1, exp_sym: 3'd4};
        vecs[2] = '{dec: 4'b0000, best: 2'd2, exp_sym: 3'd5};
        vecs[3] = '{dec: 4'b0100, best: 2'd2, exp_sym: 3'd7};

        bus.in_valid = 1'b0; bus.dec = 4'd0; bus.sym = 12'd0;
        bus.best_state = 2'd0; bus.flush = 1'b0;
        do_reset();

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sym", 32'(bus.out_sym), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);

        // 1: fill then first RUN output
        for (int k = 1; k <= 5; k++) begin
            k3 = 3'(k);
            step0(k3, 1'b0);
            if (k < 5) begin
                check("t1_no_out", 32'(bus.out_valid), 32'd0);
            end else begin
                check("t1_out_valid", 32'(bus.out_valid), 32'd1);
                check("t1_out_sym", 32'(bus.out_sym), 32'd1);
            end
        end
        do_reset();

        // 2: predecessor map, one step then flush
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vecs[i].dec, {3'd7, 3'd6, 3'd5, 3'd4}, vecs[i].best, 1'b0);
            drive(1'b0, 4'd0, 12'd0, vecs[i].best, 1'b1);
            check("t2_drain_ready", 32'(bus.in_ready), 32'd0);
            drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
            check("t2_valid", 32'(bus.out_valid), 32'd1);
            check("t2_sym", 32'(bus.out_sym), 32'(vecs[i].exp_sym));
            check("t2_done", 32'(bus.frame_done), 32'd1);
            check("t2_ready_after", 32'(bus.in_ready), 32'd1);
        end
        do_reset();

        // 3: fill=2 drain; steps offered during drain must be ignored
        step0(3'd2, 1'b0);
        step0(3'd5, 1'b0);
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b1);
        check("t3_ready0_a", 32'(bus.in_ready), 32'd0);
        check("t3_noval", 32'(bus.out_valid), 32'd0);
        step0(3'd7, 1'b1);
        check("t3_valid1", 32'(bus.out_valid), 32'd1);
        check("t3_sym1", 32'(bus.out_sym), 32'd2);
        check("t3_done1", 32'(bus.frame_done), 32'd0);
        check("t3_ready0_b", 32'(bus.in_ready), 32'd0);
        step0(3'd7, 1'b0);
        check("t3_valid2", 32'(bus.out_valid), 32'd1);
        check("t3_sym2", 32'(bus.out_sym), 32'd5);
        check("t3_done2", 32'(bus.frame_done), 32'd1);
        check("t3_ready1", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
        check("t3_quiet_valid", 32'(bus.out_valid), 32'd0);
        check("t3_quiet_done", 32'(bus.frame_done), 32'd0);
        do_reset();

        // 4: flush alone in IDLE
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b1);
        check("t4_done", 32'(bus.frame_done), 32'd1);
        check("t4_noval", 32'(bus.out_valid), 32'd0);
        check("t4_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
        check("t4_done_clr", 32'(bus.frame_done), 32'd0);
        check("t4_noval2", 32'(bus.out_valid), 32'd0);
        do_reset();

        // 5: fill=3, step together with flush drains 4 symbols
        step0(3'd1, 1'b0);
        step0(3'd2, 1'b0);
        step0(3'd3, 1'b0);
        step0(3'd4, 1'b1);
        check("t5_noval", 32'(bus.out_valid), 32'd0);
        check("t5_ready0", 32'(bus.in_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
            check("t5_valid", 32'(bus.out_valid), 32'd1);
            check("t5_sym", 32'(bus.out_sym), 32'(k));
            check("t5_done", 32'(bus.frame_done), (k == 4) ? 32'd1 : 32'd0);
        end
        check("t5_ready1", 32'(bus.in_ready), 32'd1);

        // 6: reset mid-drain, then clean refill
        step0(3'd1, 1'b0);
        step0(3'd2, 1'b0);
        step0(3'd3, 1'b1);
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
        check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        drive(1'b0, 4'd0, 12'd0, 2'd0, 1'b0);
        reset = 1'b0;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_done", 32'(bus.frame_done), 32'd0);
        check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            k3 = 3'(k + 5);
            step0(k3, 1'b0);
            if (k < 4) begin
                check("t6_no_out", 32'(bus.out_valid), 32'd0);
                check("t6_no_done", 32'(bus.frame_done), 32'd0);
            end else begin
                check("t6_out_valid", 32'(bus.out_valid), 32'd1);
                check("t6_out_sym", 32'(bus.out_sym), 32'd5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
